// File: rtl/instr_prefetch.sv
// Instruction-fetch front end: in-order prefetch buffer with up to DEPTH fetches in flight.
// Optional RISCX_IFU_ERR_HALT_EN: a buffered bus error stops fetch until the next redirect.
module instr_prefetch #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   if_req_valid_o,
  input  logic                   if_req_ready_i,
  output logic [PC_WIDTH-1:0]    if_req_pc_o,
  input  logic                   if_resp_valid_i,
  output logic                   if_resp_ready_o,
  input  logic                   if_resp_err_i,
  input  logic [INSTR_WIDTH-1:0] if_resp_instr_i,
  output logic                   if_valid_o,
  input  logic                   if_ready_i,
  output logic [PC_WIDTH-1:0]    if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic                   if_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_WIDTH-1:0]    pc_q     [DEPTH];
  logic [PC_WIDTH-1:0]    pc_d     [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q  [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_d  [DEPTH];
  logic                   err_q    [DEPTH];
  logic                   err_d    [DEPTH];
  logic                   filled_q [DEPTH];
  logic                   filled_d [DEPTH];

  logic [PW-1:0]       alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]       count_q, count_d, drop_q, drop_d;
  // requests accepted by the bus whose response has not yet been written
  logic [CW-1:0]       outst_q, outst_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                halt_q, halt_d;

  logic req_fire, resp_fire, pop, resp_write;

  assign if_resp_ready_o = !rst;
  assign if_req_valid_o  = !rst && !redirect_valid_i && !halt_q &&
                           (({1'b0, count_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH));
  assign if_req_pc_o     = fetch_pc_q;
  assign if_valid_o      = filled_q[head_q] && !redirect_valid_i;
  assign if_pc_o         = pc_q[head_q];
  assign if_instr_o      = instr_q[head_q];
  assign if_err_o        = err_q[head_q];

  assign req_fire   = if_req_valid_o && if_req_ready_i;
  assign resp_fire  = if_resp_valid_i && if_resp_ready_o;
  assign pop        = if_valid_o && if_ready_i;
  assign resp_write = resp_fire && !redirect_valid_i && (drop_q == '0);

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    err_d      = err_q;
    filled_d   = filled_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q;
    fetch_pc_d = fetch_pc_q;
    halt_d     = halt_q;
    if (redirect_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_d[i]     = '0;
        instr_d[i]  = '0;
        err_d[i]    = 1'b0;
        filled_d[i] = 1'b0;
      end
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      count_d    = '0;
      outst_d    = '0;
      drop_d     = drop_q + outst_q - CW'(resp_fire);
      fetch_pc_d = redirect_pc_i & ~PC_WIDTH'(3);
      halt_d     = 1'b0;
    end else begin
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      if (req_fire) begin
        pc_d[alloc_q]     = fetch_pc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PW'(1);
        fetch_pc_d        = fetch_pc_q + PC_WIDTH'(4);
      end
      if (resp_fire && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_write) begin
        instr_d[fill_q]  = if_resp_err_i ? '0 : if_resp_instr_i;
        err_d[fill_q]    = if_resp_err_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
`ifdef RISCX_IFU_ERR_HALT_EN
        if (if_resp_err_i) halt_d = 1'b1;
`endif
      end
      count_d = count_q + CW'(req_fire) - CW'(pop);
      outst_d = outst_q + CW'(req_fire) - CW'(resp_write);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= '0;
        instr_q[i]  <= '0;
        err_q[i]    <= 1'b0;
        filled_q[i] <= 1'b0;
      end
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      outst_q    <= '0;
      fetch_pc_q <= RESET_PC;
      halt_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      filled_q   <= filled_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      outst_q    <= outst_d;
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halt_d;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch (DEPTH=4): vector table for streaming and backpressure,
// plus hand-written sequences for redirect, error, and mid-operation reset.
module tb_instr_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        if_req_valid_o;
  logic        if_req_ready_i;
  logic [31:0] if_req_pc_o;
  logic        if_resp_valid_i;
  logic        if_resp_ready_o;
  logic        if_resp_err_i;
  logic [31:0] if_resp_instr_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_err_o;

`ifdef RISCX_IFU_ERR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  instr_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .if_req_valid_o(if_req_valid_o), .if_req_ready_i(if_req_ready_i), .if_req_pc_o(if_req_pc_o),
    .if_resp_valid_i(if_resp_valid_i), .if_resp_ready_o(if_resp_ready_o),
    .if_resp_err_i(if_resp_err_i), .if_resp_instr_i(if_resp_instr_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o), .if_err_o(if_err_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic        rq;
    logic        rv;
    logic [31:0] rinstr;
    logic        dr;
    logic        e_rqv;
    logic [31:0] e_rqpc;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drive inputs at the negedge, let comb outputs settle
  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rq,
                       input logic rv, input logic rerr, input logic [31:0] rinstr,
                       input logic dr);
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    if_req_ready_i   = rq;
    if_resp_valid_i  = rv;
    if_resp_err_i    = rerr;
    if_resp_instr_i  = rinstr;
    if_ready_i       = dr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 32'h0,         1, 1, 32'h8000_0000, 0, 32'h0,         32'h0};
    tbl[1]  = '{1, 1, 32'h1000_0000, 1, 1, 32'h8000_0004, 0, 32'h8000_0000, 32'h0};
    tbl[2]  = '{1, 1, 32'h1000_0004, 1, 1, 32'h8000_0008, 1, 32'h8000_0000, 32'h1000_0000};
    tbl[3]  = '{1, 1, 32'h1000_0008, 1, 1, 32'h8000_000C, 1, 32'h8000_0004, 32'h1000_0004};
    tbl[4]  = '{1, 1, 32'h1000_000C, 0, 1, 32'h8000_0010, 1, 32'h8000_0008, 32'h1000_0008};
    tbl[5]  = '{1, 1, 32'h1000_0010, 0, 1, 32'h8000_0014, 1, 32'h8000_0008, 32'h1000_0008};
    tbl[6]  = '{1, 0, 32'h0,         0, 0, 32'h8000_0018, 1, 32'h8000_0008, 32'h1000_0008};
    tbl[7]  = '{1, 1, 32'h1000_0014, 0, 0, 32'h8000_0018, 1, 32'h8000_0008, 32'h1000_0008};
    tbl[8]  = '{1, 0, 32'h0,         1, 0, 32'h8000_0018, 1, 32'h8000_0008, 32'h1000_0008};
    tbl[9]  = '{1, 0, 32'h0,         0, 1, 32'h8000_0018, 1, 32'h8000_000C, 32'h1000_000C};
    tbl[10] = '{1, 0, 32'h0,         0, 0, 32'h8000_001C, 1, 32'h8000_000C, 32'h1000_000C};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_req_valid", 32'(if_req_valid_o), 32'h0);
    chk("rst_req_pc", if_req_pc_o, 32'h8000_0000);
    chk("rst_resp_ready", 32'(if_resp_ready_o), 32'h0);
    chk("rst_if_valid", 32'(if_valid_o), 32'h0);
    chk("rst_if_pc", if_pc_o, 32'h0);
    chk("rst_if_instr", if_instr_o, 32'h0);
    chk("rst_if_err", 32'(if_err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // streaming, then backpressure until the 4-entry buffer is full, then one pop
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, tbl[i].rq, tbl[i].rv, 0, tbl[i].rinstr, tbl[i].dr);
      chk($sformatf("vec%0d_req_valid", i), 32'(if_req_valid_o), 32'(tbl[i].e_rqv));
      chk($sformatf("vec%0d_req_pc", i), if_req_pc_o, tbl[i].e_rqpc);
      chk($sformatf("vec%0d_if_valid", i), 32'(if_valid_o), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_if_pc", i), if_pc_o, tbl[i].e_pc);
      chk($sformatf("vec%0d_if_instr", i), if_instr_o, tbl[i].e_instr);
      chk($sformatf("vec%0d_resp_ready", i), 32'(if_resp_ready_o), 32'h1);
      next_cycle();
    end

    // redirect with 3 requests outstanding
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 1);
      next_cycle();
    end
    drive(1, 32'h0000_1003, 1, 0, 0, 0, 1);
    chk("rdA_if_valid", 32'(if_valid_o), 32'h0);
    chk("rdA_req_valid", 32'(if_req_valid_o), 32'h0);
    next_cycle();
    drive(0, 0, 1, 1, 0, 32'hBAD0_0000, 1);
    chk("rdA_first_req_valid", 32'(if_req_valid_o), 32'h1);
    chk("rdA_first_req_pc", if_req_pc_o, 32'h0000_1000);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 32'hBAD0_0001 + 32'(i), 1);
      chk($sformatf("rdA_drop%0d_if_valid", i), 32'(if_valid_o), 32'h0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 32'h0000_0055, 1);
    chk("rdA_pre_if_valid", 32'(if_valid_o), 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rdA_deliv_valid", 32'(if_valid_o), 32'h1);
    chk("rdA_deliv_pc", if_pc_o, 32'h0000_1000);
    chk("rdA_deliv_instr", if_instr_o, 32'h0000_0055);
    next_cycle();

    // redirect coincident with a response and a pop: 2 unfilled - 1 response = 1 drop
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 32'h0000_0011, 0);
    next_cycle();
    drive(1, 32'h0000_2000, 0, 1, 0, 32'h0000_0022, 1);
    chk("rdB_if_valid", 32'(if_valid_o), 32'h0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'hBAD0_0033, 1);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("rdB_if_valid_after_drop", 32'(if_valid_o), 32'h0);
    chk("rdB_req_valid", 32'(if_req_valid_o), 32'h1);
    chk("rdB_req_pc", if_req_pc_o, 32'h0000_2000);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h0000_0066, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rdB_deliv_valid", 32'(if_valid_o), 32'h1);
    chk("rdB_deliv_pc", if_pc_o, 32'h0000_2000);
    chk("rdB_deliv_instr", if_instr_o, 32'h0000_0066);
    next_cycle();

    // bus error on 8000_0004
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 32'h0000_0077, 0);
    next_cycle();
    drive(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("err_head0_pc", if_pc_o, 32'h8000_0000);
    chk("err_head0_err", 32'(if_err_o), 32'h0);
    chk("err_head0_instr", if_instr_o, 32'h0000_0077);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("err_head1_valid", 32'(if_valid_o), 32'h1);
    chk("err_head1_pc", if_pc_o, 32'h8000_0004);
    chk("err_head1_err", 32'(if_err_o), 32'h1);
    chk("err_head1_instr", if_instr_o, 32'h0);
    chk("err_req_after", 32'(if_req_valid_o), HALT_EN ? 32'h0 : 32'h1);
    chk("err_req_pc", if_req_pc_o, 32'h8000_0008);
    next_cycle();
    drive(1, 32'h0000_3000, 1, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("err_redir_req_valid", 32'(if_req_valid_o), 32'h1);
    chk("err_redir_req_pc", if_req_pc_o, 32'h0000_3000);
    next_cycle();

    // reset while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 0, 32'h0000_0100 + 32'(i), 0);
      next_cycle();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("full_req_valid", 32'(if_req_valid_o), 32'h0);
    chk("full_if_valid", 32'(if_valid_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(if_req_valid_o), 32'h0);
    chk("midrst_req_pc", if_req_pc_o, 32'h8000_0000);
    chk("midrst_resp_ready", 32'(if_resp_ready_o), 32'h0);
    chk("midrst_if_valid", 32'(if_valid_o), 32'h0);
    chk("midrst_if_pc", if_pc_o, 32'h0);
    chk("midrst_if_instr", if_instr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_req_valid", 32'(if_req_valid_o), 32'h1);
    chk("postrst_req_pc", if_req_pc_o, 32'h8000_0000);
    chk("postrst_resp_ready", 32'(if_resp_ready_o), 32'h1);
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Parametrised instruction-fetch front end with an in-order prefetch buffer. It replaces the single-request fetch path between the PC register and the IF/ID register. It keeps up to DEPTH requests in flight on the instruction memory bus and buffers returned instructions with their PCs. It delivers them to decode over a valid/ready handshake, and a redirect from execute flushes the buffer and restarts fetch at a new PC.

## Interface
- PC_WIDTH, 32, PC and request address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, buffer entries and maximum in-flight requests; power of two, 2..16
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- redirect_valid_i  input  1  flush and restart fetch
- redirect_pc_i  input  PC_WIDTH  restart PC; bit [1:0] ignored, forced 0
- if_req_valid_o  output  1  fetch request valid
- if_req_ready_i  input  1  bus accepts request
- if_req_pc_o  output  PC_WIDTH  request address
- if_resp_valid_i  input  1  response valid; responses are in request order
- if_resp_ready_o  output  1  always 1 out of reset
- if_resp_err_i  input  1  bus error for this response
- if_resp_instr_i  input  INSTR_WIDTH  fetched word
- if_valid_o  output  1  head entry valid to decode
- if_ready_i  input  1  decode accepts
- if_pc_o  output  PC_WIDTH  head entry PC
- if_instr_o  output  INSTR_WIDTH  head entry instruction; 0 when if_err_o=1
- if_err_o  output  1  head entry carries a bus error

## Operation
- Buffer structure: circular buffer of DEPTH entries, each holding {pc, instr, err, filled}.
  - Pointers: alloc, fill, head, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count: clog2(DEPTH)+1 bits.
- Request issue: if_req_valid_o = !rst && !redirect_valid_i && !halt && (count + drop_cnt < DEPTH).
  - if_req_pc_o = fetch PC.
  - On request fire: allocate the entry at alloc with pc = fetch PC and filled = 0; fetch PC += 4 with modulo-2^PC_WIDTH wrap.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise the entry at fill is written with instr (0 on error), err, and filled = 1, and fill advances.
- Output: if_valid_o = head entry filled && !redirect_valid_i. On if_valid_o && if_ready_i, head advances and count decrements.
- Redirect cycle:
  - All entries are cleared, pointers reset to 0, count = 0, fetch PC = redirect_pc_i, halt cleared.
  - drop_cnt_next = drop_cnt + (unfilled allocated entries) − (resp fire this cycle ? 1 : 0). A response arriving in the redirect cycle is always discarded.
  - No request, response write, or pop takes effect in that cycle.
- Simultaneous request allocate, response fill and pop in one cycle are all legal.
- Full condition: count + drop_cnt = DEPTH. The request is held low until a pop or a drop frees a slot.
- Empty condition: if_valid_o = 0, even with requests outstanding.

## Timing
- Reset values: if_req_valid_o=0, if_req_pc_o=RESET_PC, if_resp_ready_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, if_err_o=0, drop_cnt=0, count=0, halt=0.
- First request: if_req_valid_o rises in the first cycle after rst deasserts, with PC RESET_PC.
- Latency:
  - Response accepted in cycle N gives if_valid_o=1 in cycle N+1 if that entry is the head.
  - Request-to-request throughput is 1 per cycle while credit is available.
- Redirect in cycle N: first request to redirect_pc_i appears in cycle N+1.
- The bus must not deliver more responses than requests accepted; behaviour on extra responses is undefined.
- rst mid-operation: all state clears asynchronously; in-flight responses after reset are not dropped, and the bus must also be reset.

## Configuration
- RISCX_IFU_ERR_HALT_EN
  - Defined: a response with if_resp_err_i=1 that is written (not dropped) sets halt. No further requests issue until redirect_valid_i; buffered entries still drain normally.
  - Undefined: errors are flagged per entry only and fetch continues sequentially.

## Test plan
- Reset then if_req_ready_i=1, responses with 1-cycle delay, if_ready_i=1 → requests at 8000_0000, 8000_0004, 8000_0008…; decode receives matching PCs, one per cycle after initial latency.
- DEPTH=4, if_ready_i=0 → exactly 4 requests issued, if_req_valid_o then held 0. One pop → exactly 1 new request.
- Redirect to 0000_1000 with 3 requests outstanding → if_valid_o=0 that cycle. The next 3 responses are discarded, and the first delivered PC is 0000_1000.
- Redirect coincident with a response and a pop → response discarded, pop ignored, drop_cnt = outstanding−1.
- Error response on PC 8000_0004 → if_err_o=1, if_instr_o=0 at that entry.
  - With RISCX_IFU_ERR_HALT_EN: no request after that write until redirect.
  - Without it: fetch continues.
- rst asserted while the buffer is full → all outputs at reset values immediately; first request after release is at RESET_PC.
